// File: rtl/video_pkg.sv
// video_pkg: shared video types and constants for the tile/sprite mapper.
//   rgb_t           - 24-bit packed RGB pixel
//   TILE_SHIFT      - log2 of the tile edge in pixels
//   TILE_PIX        - pixels per tile (16x16)
//   SCREEN_W        - visible screen width in pixels
//   DEFAULT_KEY_RGB - default transparent colour key for sprites
package video_pkg;

  typedef logic [23:0] rgb_t;

  localparam int   TILE_SHIFT      = 4;
  localparam int   TILE_PIX        = 256;
  localparam int   SCREEN_W        = 640;
  localparam rgb_t DEFAULT_KEY_RGB = 24'hEE35FF;

endpackage

// File: rtl/sprite_channel.sv
// sprite_channel: one sprite lane of the mapper pipeline.
//   S0 (pix_en_i): hit test against the sprite box, mirror, ROM address.
//   S1 (pix_en_i): capture the sprite ROM pixel returned for that address.
// Ports:
//   clk_i, rst_ni        - clock, async active-low reset
//   pix_en_i             - pixel strobe
//   en_i, mirror_i       - channel enable, horizontal flip
//   draw_x_i, draw_y_i   - current screen pixel
//   spr_x_i, spr_y_i     - sprite top-left on screen
//   rom_data_i           - sprite ROM pixel (1 clk after rom_addr_o)
//   rom_addr_o           - sprite ROM address (S0 register)
//   hit_o                - S0 hit flag
//   data_o               - S1 captured sprite pixel
module sprite_channel
  import video_pkg::*;
#(
  parameter int SPR_SIZE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pix_en_i,
  input  logic       en_i,
  input  logic       mirror_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic [9:0] spr_x_i,
  input  logic [9:0] spr_y_i,
  input  rgb_t       rom_data_i,
  output logic [7:0] rom_addr_o,
  output logic       hit_o,
  output rgb_t       data_o
);

  localparam int SW = $clog2(SPR_SIZE);

  logic [10:0]   x_end_s;
  logic [10:0]   y_end_s;
  logic [SW-1:0] sx_s;
  logic [SW-1:0] sy_s;
  logic [SW-1:0] col_s;
  logic          hit_d;
  logic [7:0]    addr_d;

  logic [7:0]    addr_q;
  logic          hit_q;
  rgb_t          data_q;

  // Hit test and ROM address; box ends are 11 bits so sprites near the
  // right/bottom edge clip instead of wrapping.
  always_comb begin
    x_end_s = {1'b0, spr_x_i} + 11'(SPR_SIZE);
    y_end_s = {1'b0, spr_y_i} + 11'(SPR_SIZE);
    sx_s    = SW'(draw_x_i - spr_x_i);
    sy_s    = SW'(draw_y_i - spr_y_i);
    hit_d   = en_i
            && (draw_x_i >= spr_x_i) && ({1'b0, draw_x_i} < x_end_s)
            && (draw_y_i >= spr_y_i) && ({1'b0, draw_y_i} < y_end_s);
    if (mirror_i) begin
      col_s = SW'(SPR_SIZE - 1) - sx_s;
    end else begin
      col_s = sx_s;
    end
    addr_d = 8'({sy_s, col_s});
  end

  // S0 address/hit and S1 data registers, advanced on the pixel strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= 8'd0;
      hit_q  <= 1'b0;
      data_q <= 24'd0;
    end else if (pix_en_i) begin
      addr_q <= addr_d;
      hit_q  <= hit_d;
      data_q <= rom_data_i;
    end
  end

  assign rom_addr_o = addr_q;
  assign hit_o      = hit_q;
  assign data_o     = data_q;

endmodule

// File: rtl/scroll_tile_mapper.sv
// scroll_tile_mapper: scrolling 16x16-tile background plus NUM_SPR keyed,
// mirrorable sprites, composed through a 3-strobe registered pipeline.
// Ports:
//   Clk, Reset_n            - clock, async active-low reset
//   pix_en                  - pixel strobe (pipeline advance)
//   frame_start             - one-clock pulse at start of vertical blank
//   DrawX, DrawY, blank     - VGA timing inputs (blank=1 is active video)
//   scroll_en               - allow sprite 0 to push the scroll
//   spr_en, spr_mirror      - per-sprite enable / horizontal flip
//   spr_x, spr_y            - packed sprite positions, 10 bits per channel
//   map_addr / map_data     - world map ROM (1 clk latency)
//   tile_addr / tile_data   - tile pixel ROM (1 clk latency)
//   spr_rom_addr / _data    - per-sprite ROMs (1 clk latency)
//   scroll_x                - world X offset, 0..WORLD_W-1
//   Red, Green, Blue        - registered pixel output
module scroll_tile_mapper
  import video_pkg::*;
#(
  parameter int   NUM_SPR         = 2,
  parameter int   SPR_SIZE        = 16,
  parameter int   MAP_COLS        = 40,
  parameter int   ANIM_TILE       = 6,
  parameter int   ANIM_FRAMES     = 3,
  parameter int   ANIM_STRIDE     = 2,
  parameter int   ANIM_PERIOD     = 21,
  parameter int   SCROLL_THRESH   = 240,
  parameter int   SCROLL_MAX_STEP = 8,
  parameter rgb_t KEY_RGB         = DEFAULT_KEY_RGB
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  pix_en,
  input  logic                  frame_start,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  input  logic                  scroll_en,
  input  logic [NUM_SPR-1:0]    spr_en,
  input  logic [NUM_SPR-1:0]    spr_mirror,
  input  logic [NUM_SPR*10-1:0] spr_x,
  input  logic [NUM_SPR*10-1:0] spr_y,
  output logic [10:0]           map_addr,
  input  logic [4:0]            map_data,
  output logic [12:0]           tile_addr,
  input  logic [23:0]           tile_data,
  output logic [NUM_SPR*8-1:0]  spr_rom_addr,
  input  logic [NUM_SPR*24-1:0] spr_rom_data,
  output logic [9:0]            scroll_x,
  output logic [7:0]            Red,
  output logic [7:0]            Green,
  output logic [7:0]            Blue
);

  localparam int          WORLD_W   = MAP_COLS * 16;
  localparam logic [10:0] WORLD_W_L = 11'(WORLD_W);
  localparam int          CNT_W     = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam int          PH_W      = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  // Frame-rate state
  logic [9:0]       scroll_q, scroll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [9:0]       push_s;
  logic [9:0]       step_s;
  logic [10:0]      scroll_sum_s;

  // Pixel pipeline state
  logic [10:0]        wx_sum_s;
  logic [9:0]         wx_s;
  logic [10:0]        map_addr_q, map_addr_d;
  logic [3:0]         col_q, row_q;
  logic               blank_s0_q, blank_s1_q;
  logic [NUM_SPR-1:0] hit_s0_s, hit_s1_q;
  logic [4:0]         tile_s;
  logic [12:0]        tile_addr_q, tile_addr_d;
  rgb_t               spr_data_s [NUM_SPR];
  rgb_t               rgb_q, rgb_d;

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    sprite_channel #(.SPR_SIZE(SPR_SIZE)) u_chan (
      .clk_i      (Clk),
      .rst_ni     (Reset_n),
      .pix_en_i   (pix_en),
      .en_i       (spr_en[g]),
      .mirror_i   (spr_mirror[g]),
      .draw_x_i   (DrawX),
      .draw_y_i   (DrawY),
      .spr_x_i    (spr_x[10*g +: 10]),
      .spr_y_i    (spr_y[10*g +: 10]),
      .rom_data_i (spr_rom_data[24*g +: 24]),
      .rom_addr_o (spr_rom_addr[8*g +: 8]),
      .hit_o      (hit_s0_s[g]),
      .data_o     (spr_data_s[g])
    );
  end

  // Scroll advance: sprite 0 past the threshold pushes the world, step capped.
  always_comb begin
    scroll_d     = scroll_q;
    push_s       = 10'd0;
    step_s       = 10'd0;
    scroll_sum_s = 11'd0;
    if (frame_start && scroll_en && (spr_x[9:0] > 10'(SCROLL_THRESH))) begin
      push_s = spr_x[9:0] - 10'(SCROLL_THRESH);
      if (push_s > 10'(SCROLL_MAX_STEP)) begin
        step_s = 10'(SCROLL_MAX_STEP);
      end else begin
        step_s = push_s;
      end
      scroll_sum_s = {1'b0, scroll_q} + {1'b0, step_s};
      if (scroll_sum_s >= WORLD_W_L) begin
        scroll_d = 10'(scroll_sum_s - WORLD_W_L);
      end else begin
        scroll_d = scroll_sum_s[9:0];
      end
    end else begin
      scroll_d = scroll_q;
    end
  end

  // Animation period counter and phase, stepped once per frame.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (cnt_q == CNT_W'(ANIM_PERIOD - 1)) begin
        cnt_d = '0;
        if (phase_q == PH_W'(ANIM_FRAMES - 1)) begin
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // S0/S1 address generation; frame-rate state is only read here, so a
  // coincident frame_start still addresses this pixel with the old scroll.
  always_comb begin
    wx_sum_s = {1'b0, DrawX} + {1'b0, scroll_q};
    if (wx_sum_s >= WORLD_W_L) begin
      wx_s = 10'(wx_sum_s - WORLD_W_L);
    end else begin
      wx_s = wx_sum_s[9:0];
    end
    map_addr_d = 11'(wx_s[9:4]) + 11'(DrawY[9:4]) * 11'(MAP_COLS);
    if (map_data == 5'(ANIM_TILE)) begin
      tile_s = 5'(ANIM_TILE) + 5'(ANIM_STRIDE) * 5'(phase_q);
    end else begin
      tile_s = map_data;
    end
    tile_addr_d = {tile_s, row_q, col_q};
  end

  // Compose: lowest-index opaque sprite wins, else background; blank forces 0.
  always_comb begin
    rgb_d = tile_data;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_s1_q[i] && (spr_data_s[i] != KEY_RGB)) begin
        rgb_d = spr_data_s[i];
      end else begin
        rgb_d = rgb_d;
      end
    end
    if (!blank_s1_q) begin
      rgb_d = 24'd0;
    end else begin
      rgb_d = rgb_d;
    end
  end

  // Frame-rate registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scroll_q <= 10'd0;
      cnt_q    <= '0;
      phase_q  <= '0;
    end else begin
      scroll_q <= scroll_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Pixel pipeline registers, advanced only on the strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      map_addr_q  <= 11'd0;
      col_q       <= 4'd0;
      row_q       <= 4'd0;
      blank_s0_q  <= 1'b0;
      blank_s1_q  <= 1'b0;
      hit_s1_q    <= '0;
      tile_addr_q <= 13'd0;
      rgb_q       <= 24'd0;
    end else if (pix_en) begin
      map_addr_q  <= map_addr_d;
      col_q       <= wx_s[3:0];
      row_q       <= DrawY[3:0];
      blank_s0_q  <= blank;
      blank_s1_q  <= blank_s0_q;
      hit_s1_q    <= hit_s0_s;
      tile_addr_q <= tile_addr_d;
      rgb_q       <= rgb_d;
    end
  end

  assign map_addr  = map_addr_q;
  assign tile_addr = tile_addr_q;
  assign scroll_x  = scroll_q;
  assign Red       = rgb_q[23:16];
  assign Green     = rgb_q[15:8];
  assign Blue      = rgb_q[7:0];

endmodule
